// File: rtl/sync_receiver_baud.sv
// rtl/sync_receiver_baud.sv - 16x oversampling serial receiver (8N1), idle-high line.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 vote of ticks 7/8/9.
module sync_receiver_baud #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       IN_ser,
   output logic [7:0] Data_out,
   output logic       Data_valid,
   output logic       Frame_err,
   output logic       Busy,
   output logic       CLK_Baud
);

   localparam int DIV = CLK_FREQ / (16 * BAUD);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [3:0] D_TICK = 4'd9;
`else
   localparam logic [3:0] D_TICK = 4'd7;
`endif

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync2_q;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          rx_s, baud_tick, bit_val;

   assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
   logic s7_q, s7_d, s8_q, s8_d;

   always_comb begin
      s7_d = s7_q;
      s8_d = s8_q;
      if (baud_tick && tick_q == 4'd7) s7_d = rx_s;
      if (baud_tick && tick_q == 4'd8) s8_d = rx_s;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s7_q <= 1'b1;
         s8_q <= 1'b1;
      end else begin
         s7_q <= s7_d;
         s8_q <= s8_d;
      end
   end

   // Decision happens at tick 9, so the third vote is the live sample.
   assign bit_val = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
`else
   assign bit_val = rx_s;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         div_q   <= '0;
         state_q <= IDLE;
         tick_q  <= 4'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= IN_ser;
         sync2_q <= sync1_q;
         div_q   <= div_d;
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign baud_tick = (div_q == DIV_LAST);

   always_comb begin
      div_d   = baud_tick ? '0 : div_q + DW'(1);
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      if (baud_tick) begin
         tick_d = tick_q + 4'd1;
         case (state_q)
            IDLE: begin
               tick_d = 4'd0;
               if (!rx_s) state_d = START;
            end
            START: begin
               if (tick_q == D_TICK && bit_val) begin
                  state_d = IDLE;
                  tick_d  = 4'd0;
               end else if (tick_q == 4'd15) begin
                  state_d = DATA;
                  bit_d   = 3'd0;
               end
            end
            DATA: begin
               if (tick_q == D_TICK) shift_d = {bit_val, shift_q[7:1]};
               if (tick_q == 4'd15) begin
                  if (bit_q == 3'd7) state_d = STOP;
                  else               bit_d   = bit_q + 3'd1;
               end
            end
            STOP: begin
               // Leave at the decision tick so a following start edge is not missed.
               if (tick_q == D_TICK) begin
                  tick_d = 4'd0;
                  if (bit_val) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                     state_d = IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = WAIT_IDLE;
                  end
               end
            end
            WAIT_IDLE: begin
               tick_d = 4'd0;
               if (rx_s) state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               tick_d  = 4'd0;
            end
         endcase
      end
   end

   assign Data_out   = data_q;
   assign Data_valid = valid_q;
   assign Frame_err  = ferr_q;
   assign Busy       = (state_q != IDLE);
   assign CLK_Baud   = baud_tick;

endmodule

// File: tb/tb_sync_receiver_baud.sv
// tb/tb_sync_receiver_baud.sv - directed bench for sync_receiver_baud (DIV=4, 64 CLK per bit).
module tb_sync_receiver_baud;

   logic       CLK = 1'b0;
   logic       RST;
   logic       IN_ser;
   logic [7:0] Data_out;
   logic       Data_valid;
   logic       Frame_err;
   logic       Busy;
   logic       CLK_Baud;

   int n_cmp = 0;
   int n_err = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int both_cnt = 0;
   logic [7:0] cap [0:15];

   sync_receiver_baud #(.CLK_FREQ(640000), .BAUD(10000)) dut (
      .CLK(CLK), .RST(RST), .IN_ser(IN_ser), .Data_out(Data_out),
      .Data_valid(Data_valid), .Frame_err(Frame_err), .Busy(Busy), .CLK_Baud(CLK_Baud)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (Data_valid) begin
         if (valid_cnt < 16) cap[valid_cnt] = Data_out;
         valid_cnt++;
      end
      if (Frame_err) ferr_cnt++;
      if (Data_valid && Frame_err) both_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic align_baud();
      bit found = 1'b0;
      for (int k = 0; k < 16 && !found; k++) begin
         @(posedge CLK); #1;
         if (CLK_Baud) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_err++;
         $display("FAIL align: CLK_Baud seen %0d required 1", found);
      end
   endtask

   // Bit i of the frame lasts 64 CLK; glitch_idx forces cycles 32..35 of that bit high.
   task automatic send_frame(input logic [7:0] b, input logic stop_b, input int glitch_idx);
      logic [9:0] bits;
      bits = {stop_b, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < 64; c++) begin
            @(posedge CLK); #1;
            IN_ser = bits[i];
            if (i == glitch_idx && c >= 32 && c < 36) IN_ser = 1'b1;
         end
      end
   endtask

   task automatic check_byte(input string name, input int v0, input logic [7:0] exp);
      n_cmp++;
      if (valid_cnt - v0 !== 1) begin
         n_err++;
         $display("FAIL %s_count: got %0d required 1", name, valid_cnt - v0);
      end
      n_cmp++;
      if (Data_out !== exp) begin
         n_err++;
         $display("FAIL %s_data: got %h required %h", name, Data_out, exp);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      IN_ser = 1'b1;
      idle(3);
      n_cmp++; if (Data_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h required 00", Data_out); end
      n_cmp++; if (Data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", Data_valid); end
      n_cmp++; if (Frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b required 0", Frame_err); end
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", Busy); end
      n_cmp++; if (CLK_Baud !== 1'b0) begin n_err++; $display("FAIL reset_baud: got %b required 0", CLK_Baud); end
      RST = 1'b0;
      idle(10);
   endtask

   task automatic test_single();
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      align_baud();
      send_frame(8'h14, 1'b1, -1);
      idle(40);
      check_byte("single", v0, 8'h14);
      n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL single_ferr: got %0d required 0", ferr_cnt - f0); end
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b required 0", Busy); end
   endtask

   task automatic test_back_to_back();
      int v0 = valid_cnt;
      align_baud();
      send_frame(8'h14, 1'b1, -1);
      send_frame(8'h46, 1'b1, -1);
      idle(40);
      n_cmp++; if (valid_cnt - v0 !== 2) begin n_err++; $display("FAIL b2b_count: got %0d required 2", valid_cnt - v0); end
      n_cmp++; if (cap[v0] !== 8'h14) begin n_err++; $display("FAIL b2b_first: got %h required 14", cap[v0]); end
      n_cmp++; if (cap[v0+1] !== 8'h46) begin n_err++; $display("FAIL b2b_second: got %h required 46", cap[v0+1]); end
   endtask

   task automatic test_glitch();
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      align_baud();
      for (int c = 0; c < 12; c++) begin
         @(posedge CLK); #1;
         IN_ser = 1'b0;
         if (c == 10) begin
            n_cmp++;
            if (Busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_mid: got %b required 1", Busy); end
         end
      end
      @(posedge CLK); #1;
      IN_ser = 1'b1;
      idle(100);
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got %b required 0", Busy); end
      n_cmp++;
      if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin
         n_err++;
         $display("FAIL glitch_pulses: got %0d/%0d required 0/0", valid_cnt - v0, ferr_cnt - f0);
      end
      v0 = valid_cnt;
      align_baud();
      send_frame(8'hA5, 1'b1, -1);
      idle(40);
      check_byte("after_glitch", v0, 8'hA5);
   endtask

   task automatic test_frame_err();
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      align_baud();
      send_frame(8'h3C, 1'b0, -1);
      idle(300);
      n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL ferr_break_busy: got %b required 1", Busy); end
      IN_ser = 1'b1;
      idle(100);
      n_cmp++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_count: got %0d required 1", ferr_cnt - f0); end
      n_cmp++; if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL ferr_valid: got %0d required 0", valid_cnt - v0); end
      n_cmp++; if (Data_out !== 8'hA5) begin n_err++; $display("FAIL ferr_data_kept: got %h required a5", Data_out); end
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL ferr_recover: got %b required 0", Busy); end
      v0 = valid_cnt;
      align_baud();
      send_frame(8'h5A, 1'b1, -1);
      idle(40);
      check_byte("after_ferr", v0, 8'h5A);
   endtask

   task automatic test_reset_midframe();
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      logic [9:0] bits;
      bits = {1'b1, 8'hFF, 1'b0};
      align_baud();
      for (int i = 0; i < 6; i++) begin
         for (int c = 0; c < 64 && !(i == 5 && c >= 32); c++) begin
            @(posedge CLK); #1;
            IN_ser = bits[i];
         end
      end
      n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b required 1", Busy); end
      RST = 1'b1;
      @(posedge CLK); #1;
      n_cmp++; if (Data_out !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h required 00", Data_out); end
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b required 0", Busy); end
      n_cmp++;
      if (Data_valid !== 1'b0 || Frame_err !== 1'b0 || CLK_Baud !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_pulses: got %b%b%b required 000", Data_valid, Frame_err, CLK_Baud);
      end
      RST = 1'b0;
      IN_ser = 1'b1;
      idle(400);
      n_cmp++;
      if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin
         n_err++;
         $display("FAIL midrst_no_pulse: got %0d/%0d required 0/0", valid_cnt - v0, ferr_cnt - f0);
      end
      align_baud();
      send_frame(8'h81, 1'b1, -1);
      idle(40);
      check_byte("after_rst", v0, 8'h81);
   endtask

   task automatic test_majority();
      int v0 = valid_cnt;
      logic [7:0] exp;
`ifdef UART_RX_MAJORITY_EN
      exp = 8'h00;
`else
      exp = 8'h04;
`endif
      align_baud();
      send_frame(8'h00, 1'b1, 3);
      idle(40);
      check_byte("majority", v0, exp);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_midframe();
      test_majority();
      n_cmp++;
      if (both_cnt !== 0) begin n_err++; $display("FAIL exclusive_pulses: got %0d required 0", both_cnt); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sync_receiver_baud.md
SYNC_RECEIVER_BAUD -- requirements
Module: sync_receiver_baud

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port IN_ser  input  1  asynchronous serial line (idle high, 1 start, 8 data LSB-first, 1 stop, no parity), driven by Sync_Transmitter_Baud OUT_ser.
REQ-006 SHALL have port Data_out  output  8  last correctly received byte.
REQ-007 SHALL have port Data_valid  output  1  one-CLK pulse: Data_out updated.
REQ-008 SHALL have port Frame_err  output  1  one-CLK pulse: stop bit sampled low.
REQ-009 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port CLK_Baud  output  1  one-CLK pulse at 16x BAUD (oversample tick).

Function
REQ-011 SHALL pass IN_ser through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s.
REQ-012 SHALL compute DIV = CLK_FREQ/(16*BAUD), integer-truncated (default 325); free-running divider counts 0..DIV-1 and asserts CLK_Baud for exactly one CLK when count = DIV-1, then wraps to 0.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_IDLE; all state, tick_cnt (4 bit) and bit_cnt (3 bit) updates occur only on CLK_Baud cycles.
REQ-014 IDLE: on tick with rx_s=0 -> START, tick_cnt=0; otherwise remain.
REQ-015 Bit window: tick_cnt increments each tick 0..15; decision tick D = 7 (see REQ-024); window advance at tick_cnt=15 with tick_cnt wrapping to 0.
REQ-016 START: at D, bit value 1 -> IDLE (glitch rejected, no pulse); value 0 -> stay; at tick_cnt=15 -> DATA, bit_cnt=0.
REQ-017 DATA: at D shift bit value into shift register at MSB, shifting right (LSB-first reception); at tick_cnt=15, bit_cnt=7 -> STOP, else bit_cnt+1.
REQ-018 STOP: at D, value 1 -> Data_out <= shift register, Data_valid=1 for the following CLK, -> IDLE immediately (not waiting for tick 15).
REQ-019 STOP: at D, value 0 -> Frame_err=1 for the following CLK, Data_out unchanged, -> WAIT_IDLE.
REQ-020 WAIT_IDLE: on tick with rx_s=1 -> IDLE; line held low (break) produces no further pulses.
REQ-021 Data_valid and Frame_err SHALL never be high in the same cycle and SHALL be low in every other cycle.
REQ-022 Back-to-back frames: a start edge arriving within 1 tick after REQ-018 completion SHALL be received without loss.

Reset
REQ-023 RST=1 on a CLK edge, at any time including mid-frame, SHALL force: state IDLE, divider 0, tick_cnt 0, bit_cnt 0, shift register 0x00, Data_out 0x00, Data_valid 0, Frame_err 0, Busy 0, CLK_Baud 0, synchronizer flops 1; partial frame discarded, no pulse.

Configuration
REQ-024 Macro UART_RX_MAJORITY_EN: defined -> each bit value is the 2-of-3 majority of rx_s sampled at tick_cnt 7, 8, 9 and D = 9; undefined -> bit value is rx_s at tick_cnt 7 and D = 7; all other behaviour identical.

Verification (sim with CLK_FREQ=640000, BAUD=10000 -> DIV=4, 1 bit = 64 CLK)
REQ-025 Send 0x14 -> exactly one Data_valid pulse, Data_out=0x14, Frame_err never high, Busy low after pulse.
REQ-026 Send 0x14 then 0x46 back-to-back (stop immediately followed by start) -> two Data_valid pulses, Data_out 0x14 then 0x46.
REQ-027 IN_ser low for 12 CLK (3 ticks) then high -> no pulse, FSM returns to IDLE, next frame 0xA5 received correctly.
REQ-028 Frame 0x3C with stop bit low, line held low 300 CLK then high -> one Frame_err pulse, Data_out keeps previous value, no Data_valid; next frame 0x5A received.
REQ-029 RST pulse during bit 4 of 0xFF -> all outputs at reset values next cycle, no pulse; subsequent 0x81 received.
REQ-030 0x00 with IN_ser forced high for 4 CLK at tick 7 of bit 2 -> with UART_RX_MAJORITY_EN Data_out=0x00; without, Data_out=0x04.
